// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/prog_loader_hold_timer.sv
// Loadable 4-bit down-counter; term flags the last cycle of the flush window.
module hold_timer
  import prog_loader_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       term
);

  logic [3:0] cnt_q, cnt_d;

  // Next count: load has priority, then count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == 4'd1);

endmodule

// File: rtl/register.sv
// Generic enable register with synchronous clear, shared with the data path.
module register #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage element: clear wins, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams instruction words into imem, holds the CPU in reset while loading
// and for HOLD_CYC cycles after, and keeps an additive image checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_clear,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      HOLD_VAL = 4'(HOLD_CYC);

  state_e                    state_q, state_d;
  logic [ADDR_W:0]           cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [WORD_W-1:0]         sum_q, sum_d;
  logic                      err_q, err_d;
  logic                      xfer, len_ok, hold_load, hold_term;
  logic [ADDR_W+WORD_W-1:0]  wr_q;

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_RUN);
  assign cpu_clear = (state_q != ST_RUN);
  assign err       = err_q;
  assign checksum  = sum_q;

  assign xfer    = in_valid & in_ready;
  assign len_ok  = (len != {(ADDR_W+1){1'b0}}) && (len <= DEPTH_L);
  // cnt is one bit wider than the address so len==DEPTH compares without wrap.
  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sum_d     = sum_q;
    err_d     = err_q;
    hold_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start && len_ok) begin
          state_d = ST_LOAD;
          len_d   = len;
          cnt_d   = {(ADDR_W+1){1'b0}};
          sum_d   = {WORD_W{1'b0}};
          err_d   = 1'b0;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          sum_d = sum_q + in_data;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d   = ST_FLUSH;
            hold_load = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (hold_term) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= {(ADDR_W+1){1'b0}};
      len_q   <= {(ADDR_W+1){1'b0}};
      sum_q   <= {WORD_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  hold_timer u_hold (
    .clk      (clk),
    .clear    (clear),
    .load     (hold_load),
    .load_val (HOLD_VAL),
    .term     (hold_term)
  );

  register #(.W(1)) u_we_reg (
    .clk   (clk),
    .clear (clear),
    .en    (1'b1),
    .d     (xfer),
    .q     (imem_we)
  );

  register #(.W(ADDR_W + WORD_W)) u_wr_reg (
    .clk   (clk),
    .clear (clear),
    .en    (xfer),
    .d     ({cnt_q[ADDR_W-1:0], in_data}),
    .q     (wr_q)
  );

  assign imem_addr  = wr_q[ADDR_W+WORD_W-1:WORD_W];
  assign imem_wdata = wr_q[WORD_W-1:0];

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader against a word-list reference model.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              clear, start, in_valid;
  logic [ADDR_W:0]   len;
  logic [31:0]       in_data;
  logic              in_ready, imem_we, cpu_clear, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata, checksum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .clear(clear), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_clear(cpu_clear), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  // Words to be loaded, and what the memory port actually saw.
  logic [31:0]       plan_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];
  logic [31:0]       obs_data_q[$];
  int   spurious, rel_lat;
  logic ready_after_start, err_after_start, clr_after_start, ready_after_last;
  bit   noise_en = 1'b0;

  function automatic logic [31:0] model_sum(input int l);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < l; i++) s = s + plan_q[i];
    return s;
  endfunction

  function automatic int count_bad_writes(input int l);
    int bad;
    bad = 0;
    if (obs_addr_q.size() != l) return l + 1;
    for (int i = 0; i < l; i++)
      if (obs_addr_q[i] !== ADDR_W'(i) || obs_data_q[i] !== plan_q[i]) bad++;
    return bad;
  endfunction

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = $urandom;
    if (noise_en) begin
      start = 1'($urandom_range(1));
      len   = (ADDR_W+1)'($urandom_range(511));
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    if (imem_we) spurious++;
  endtask

  // Drive one complete load of plan_q[0..l-1] and record observations.
  task automatic run_load(input int l, input int gap_pct, input int fixed_gap);
    int guard;
    obs_addr_q.delete();
    obs_data_q.delete();
    spurious = 0;
    @(negedge clk);
    start = 1'b1; len = l[ADDR_W:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ready_after_start = in_ready;
    err_after_start   = err;
    clr_after_start   = cpu_clear;
    for (int i = 0; i < l; i++) begin
      for (int g = 0; g < ((i > 0) ? fixed_gap : 0); g++) idle_cycle();
      while ($urandom_range(99) < gap_pct) idle_cycle();
      in_valid = 1'b1;
      in_data  = plan_q[i];
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      if (imem_we) begin
        obs_addr_q.push_back(imem_addr);
        obs_data_q.push_back(imem_wdata);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    ready_after_last = in_ready;
    rel_lat = 0;
    while (cpu_clear && rel_lat < 64) begin
      @(negedge clk);
      rel_lat++;
      if (imem_we) spurious++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b1; len = 9'd3; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_clear !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || checksum !== 32'd0 ||
          busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got clr=%b rdy=%b we=%b sum=%h busy=%b done=%b err=%b addr=%h wd=%h required 1 0 0 0 0 0 0 0 0",
                 i, cpu_clear, in_ready, imem_we, checksum, busy, done, err, imem_addr, imem_wdata);
      end
    end
  endtask

  task automatic test_basic();
    plan_q = '{32'h11, 32'h22, 32'h33};
    run_load(3, 0, 0);
    checks++;
    if (ready_after_start !== 1'b1) begin
      failures++; $display("FAIL basic_ready_latency got %b required 1", ready_after_start);
    end
    checks++;
    if (count_bad_writes(3) != 0 || spurious != 0) begin
      failures++; $display("FAIL basic_writes got %0d writes spurious=%0d required 3 in order, 0 spurious", obs_addr_q.size(), spurious);
    end
    checks++;
    if (checksum !== model_sum(3)) begin
      failures++; $display("FAIL basic_checksum got %h required %h", checksum, model_sum(3));
    end
    checks++;
    if (rel_lat != HOLD) begin
      failures++; $display("FAIL basic_release got %0d required %0d", rel_lat, HOLD);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ready_after_last !== 1'b0) begin
      failures++; $display("FAIL basic_run got done=%b busy=%b rdy_after_last=%b required 1 0 0", done, busy, ready_after_last);
    end
  endtask

  task automatic test_gap();
    plan_q = '{$urandom, $urandom};
    run_load(2, 0, 3);
    checks++;
    if (count_bad_writes(2) != 0 || spurious != 0) begin
      failures++; $display("FAIL gap_writes got %0d writes spurious=%0d required 2 at addr 0,1, 0 spurious", obs_addr_q.size(), spurious);
    end
    checks++;
    if (checksum !== model_sum(2)) begin
      failures++; $display("FAIL gap_checksum got %h required %h", checksum, model_sum(2));
    end
  endtask

  task automatic test_illegal();
    int bad_lens[2];
    bad_lens = '{0, DEPTH + 1};
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    foreach (bad_lens[k]) begin
      start = 1'b1; len = bad_lens[k][ADDR_W:0];
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_clear !== 1'b1) begin
        failures++; $display("FAIL illegal_len len=%0d got err=%b rdy=%b busy=%b clr=%b required 1 0 0 1", bad_lens[k], err, in_ready, busy, cpu_clear);
      end
    end
    plan_q = '{$urandom};
    run_load(1, 0, 0);
    checks++;
    if (err_after_start !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL illegal_recover got err=%b done=%b required 0 1", err_after_start, done);
    end
    @(negedge clk); start = 1'b1; len = 9'd0;
    @(negedge clk); start = 1'b0;
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || cpu_clear !== 1'b0) begin
      failures++; $display("FAIL illegal_in_run got err=%b done=%b clr=%b required 1 1 0", err, done, cpu_clear);
    end
  endtask

  task automatic test_full();
    plan_q.delete();
    for (int i = 0; i < DEPTH; i++) plan_q.push_back(32'hFFFF_FFFF);
    run_load(DEPTH, 0, 0);
    checks++;
    if (count_bad_writes(DEPTH) != 0 || obs_addr_q.size() == 0 || obs_addr_q[obs_addr_q.size()-1] !== 8'd255) begin
      failures++; $display("FAIL full_writes got %0d writes required %0d ending at addr 255", obs_addr_q.size(), DEPTH);
    end
    checks++;
    if (checksum !== model_sum(DEPTH)) begin
      failures++; $display("FAIL full_checksum got %h required %h", checksum, model_sum(DEPTH));
    end
    checks++;
    if (done !== 1'b1 || rel_lat != HOLD) begin
      failures++; $display("FAIL full_run got done=%b lat=%0d required 1 %0d", done, rel_lat, HOLD);
    end
  endtask

  task automatic test_clear_mid();
    logic [31:0] w;
    w = $urandom;
    @(negedge clk); start = 1'b1; len = 9'd4;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = w;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (checksum !== w) begin
      failures++; $display("FAIL clear_first_word got %h required %h", checksum, w);
    end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cpu_clear !== 1'b1 || checksum !== 32'd0 || imem_we !== 1'b0) begin
      failures++; $display("FAIL clear_mid got rdy=%b busy=%b done=%b clr=%b sum=%h we=%b required 0 0 0 1 0 0",
                           in_ready, busy, done, cpu_clear, checksum, imem_we);
    end
    plan_q = '{$urandom};
    run_load(1, 0, 0);
    plan_q = '{$urandom, $urandom};
    run_load(2, 0, 0);
    checks++;
    if (clr_after_start !== 1'b1 || ready_after_start !== 1'b1) begin
      failures++; $display("FAIL restart_from_run got clr=%b rdy=%b required 1 1", clr_after_start, ready_after_start);
    end
    checks++;
    if (checksum !== model_sum(2)) begin
      failures++; $display("FAIL restart_checksum got %h required %h", checksum, model_sum(2));
    end
  endtask

  task automatic test_random();
    int l;
    noise_en = 1'b1;
    for (int it = 0; it < 20; it++) begin
      l = $urandom_range(1, 40);
      plan_q.delete();
      for (int i = 0; i < l; i++) plan_q.push_back($urandom);
      run_load(l, $urandom_range(0, 60), 0);
      checks++;
      if (count_bad_writes(l) != 0 || spurious != 0) begin
        failures++; $display("FAIL rand_writes it=%0d got %0d writes spurious=%0d required %0d, 0 spurious", it, obs_addr_q.size(), spurious, l);
      end
      checks++;
      if (checksum !== model_sum(l) || rel_lat != HOLD || done !== 1'b1) begin
        failures++; $display("FAIL rand_result it=%0d got sum=%h lat=%0d done=%b required %h %0d 1", it, checksum, rel_lat, done, model_sum(l), HOLD);
      end
    end
    noise_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_illegal();
    test_full();
    test_clear_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader upstream of the pipelined data path. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into the instruction-memory write port. Holds the CPU in reset (`cpu_clear`) during loading and for a fixed flush window afterwards, then releases it. Reports a running additive checksum of the loaded image.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory address width; depth `DEPTH = 2**ADDR_W` words.
- `HOLD_CYC`, default 4: cycles `cpu_clear` stays high after the last word is accepted; legal range 1..15.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `clear`  in  1: synchronous active-high reset.
- `start`  in  1: begin a load; sampled only in IDLE or RUN.
- `len`  in  ADDR_W+1: word count, sampled with `start`; legal range 1..DEPTH.
- `in_valid`  in  1: `in_data` is valid.
- `in_data`  in  32: instruction word.
- `in_ready`  out  1: loader accepts a word this cycle.
- `imem_we`  out  1: instruction-memory write strobe.
- `imem_addr`  out  ADDR_W: write address.
- `imem_wdata`  out  32: write data.
- `cpu_clear`  out  1: reset to the data path; high except in RUN.
- `busy`  out  1: state is LOAD or FLUSH.
- `done`  out  1: state is RUN.
- `err`  out  1: sticky illegal-`len` flag.
- `checksum`  out  32: sum of words accepted in the current load.

## Operation
- States: IDLE, LOAD, FLUSH, RUN.
- `in_ready`, `busy`, `done` and `cpu_clear` decode directly from the state register. They must not depend on inputs.
- Transfer: `in_valid & in_ready` at a rising edge.
- IDLE -> LOAD on `start` with legal `len`:
  - Latch `len`.
  - Zero the word counter `cnt`.
  - Zero `checksum` and `err`.
- Illegal `start` (`len==0` or `len>DEPTH`) sets `err` and leaves the state unchanged (IDLE or RUN).
- LOAD, on each transfer:
  - Register `imem_we=1`, `imem_addr=cnt[ADDR_W-1:0]`, `imem_wdata=in_data` for the next cycle. `imem_we` returns to 0 when there is no transfer.
  - `checksum <= checksum + in_data`, modulo 2^32.
  - `cnt <= cnt+1`.
- The transfer with `cnt==len-1` moves the state to FLUSH and loads the hold counter with `HOLD_CYC`.
- FLUSH: decrement the hold counter each cycle; go to RUN when it reaches 1.
- RUN:
  - `cpu_clear=0`, `done=1`.
  - `start` with legal `len` re-enters LOAD, which reasserts `cpu_clear` immediately.
- `start` is ignored in LOAD and FLUSH. There is no abort other than `clear`.
- Words offered while `in_ready=0` are not consumed.

## Timing
- Reset values (after any edge with `clear=1`):
  - State IDLE; `cnt=0`, hold counter 0.
  - `cpu_clear=1`.
  - `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`.
  - `busy=0`, `done=0`, `err=0`, `checksum=0`.
- `clear` overrides every other input, including `clear` and `start` high together. `clear` in mid-LOAD abandons the load; memory contents written so far are left as is.
- `start` sampled at edge k puts `in_ready` high in cycle k+1. The first transfer can occur at edge k+1.
- Write latency: a transfer at edge t gives `imem_we` high during cycle t..t+1, with `imem_addr` and `imem_wdata` matching. `checksum` updates at the same edge t.
- Throughput: one word per cycle with `in_valid` held high.
- Last transfer at edge t:
  - `in_ready` falls in cycle t+1.
  - State enters RUN and `cpu_clear` falls at edge t+HOLD_CYC.
- The final memory write completes at least HOLD_CYC-1 cycles before the CPU leaves reset.
- `len==DEPTH`: the last address is DEPTH-1. `cnt` must not wrap before the compare.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=0, LOAD=1, FLUSH=2, RUN=3);
  - instruction word width (32);
  - default `ADDR_W`.
- The data path's generic parameterised `register` module is reused for the `imem_*` output stage.
- One sub-module is natural: `hold_timer`, a loadable 4-bit down-counter with a terminal flag, used for FLUSH.

## Test plan
- Reset, then idle 5 cycles: `cpu_clear=1`, `in_ready=0`, `imem_we=0`, `checksum=0`.
- `start`, `len=3`, words 0x11, 0x22, 0x33 back-to-back:
  - `imem_we` pulses at addresses 0, 1, 2 with those words;
  - `checksum=0x66`;
  - `cpu_clear` falls exactly 4 edges after the third transfer;
  - `done=1`.
- `len=2`, with `in_valid` low for 3 cycles between the two words: exactly 2 writes, no duplicates, addresses 0 and 1.
- `len=0`, then `len=DEPTH+1`:
  - `err=1`, state stays IDLE, `in_ready` stays 0;
  - a following legal `start` clears `err`.
- `len=DEPTH` with words 0xFFFFFFFF:
  - last write at address 255;
  - `checksum=0xFFFFFF00` (wrap);
  - reaches RUN.
- `clear` during LOAD after 1 of 4 words: IDLE next edge, `cpu_clear=1`, `checksum=0`. A `start` in RUN reasserts `cpu_clear` the next cycle.
